verin_bp_poll_master: RTL and testbench

//  Avalon-MM read master, the initiator side of the push-button PIO slave (in_port exposed as readdata[0] at address 0).

---
 rtl/verin_bp_pkg.sv | 25 ++
 rtl/verin_bp_poll_master_if.sv | 13 +
 rtl/verin_bp_debounce.sv | 65 ++++++
 rtl/verin_bp_poll_master.sv | 145 ++++++++++++++
 tb/tb_verin_bp_poll_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/verin_bp_pkg.sv
// Shared types and constants for the push-button poll master and its debouncer.
package verin_bp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_LAT    = 2'd2,
        ST_SAMPLE = 2'd3
    } bp_state_e;

    localparam int unsigned POLL_DIV_DEF     = 32'd1000;
    localparam int unsigned DEB_SAMPLES_DEF  = 32'd4;
    localparam int unsigned READ_LATENCY_DEF = 32'd1;
    localparam int unsigned BP_ADDR_DEF      = 32'd0;
    localparam int unsigned ADDR_W           = 32'd2;
    localparam int unsigned DATA_W           = 32'd32;
    localparam int unsigned STALL_W          = 32'd8;
    localparam logic [STALL_W-1:0] STALL_MAX = 8'd255;

    // Width of a down/up counter holding values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/verin_bp_poll_master_if.sv
// Avalon-MM read-only link between the poll master and the button PIO slave.
interface verin_bp_poll_master_if;
    import verin_bp_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (output address, output read, input waitrequest, input readdata);
    modport slave  (input address, input read, output waitrequest, output readdata);

endinterface

// File: rtl/verin_bp_debounce.sv
// Sample-strobed debouncer: level changes after DEB_SAMPLES consecutive differing samples.
module verin_bp_debounce
    import verin_bp_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(DEB_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 32'd1);

    logic [CW-1:0] cnt_r, cnt_s;
    logic          level_r, level_s;
    logic          rise_r, rise_s;
    logic          fall_r, fall_s;

    // Count differing samples; one matching sample restarts the run.
    always_comb begin
        cnt_s   = cnt_r;
        level_s = level_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        if (sample) begin
            if (din == level_r) begin
                cnt_s = '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_s   = '0;
                level_s = din;
                rise_s  = din;
                fall_s  = ~din;
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Debounce state and one-cycle edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/verin_bp_poll_master.sv
// Periodic Avalon-MM reader of the button PIO: poll FSM, stall watchdog, press counter.
module verin_bp_poll_master
    import verin_bp_pkg::*;
#(
    parameter int unsigned POLL_DIV     = POLL_DIV_DEF,
    parameter int unsigned DEB_SAMPLES  = DEB_SAMPLES_DEF,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
    parameter int unsigned BP_ADDR      = BP_ADDR_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    verin_bp_poll_master_if.master avm,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   bp_level,
    output logic                   bp_rise,
    output logic                   bp_fall,
    output logic [7:0]             press_count,
    output logic                   overrun
);

    localparam int unsigned TW = cnt_width(POLL_DIV);
    localparam int unsigned LW = cnt_width(READ_LATENCY);
    localparam logic [TW-1:0]     TIMER_RELOAD = TW'(POLL_DIV - 32'd1);
    localparam logic [LW-1:0]     LAT_RELOAD   = LW'(READ_LATENCY - 32'd1);
    localparam logic [ADDR_W-1:0] ADDR_C       = ADDR_W'(BP_ADDR);

    bp_state_e          state_r, state_s;
    logic [TW-1:0]      timer_r, timer_s;
    logic [LW-1:0]      lat_r, lat_s;
    logic [STALL_W-1:0] stall_r, stall_s;
    logic               read_r, read_s;
    logic               overrun_r, overrun_s;
    logic [7:0]         count_r, count_s;
    logic               ovr_set_s;
    logic               sample_s;
    logic               rise_s;
    logic               readdata_unused_s;

    // Poll sequencing; avm_read is the registered image of "next state is REQ".
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        lat_s     = lat_r;
        stall_s   = stall_r;
        ovr_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    if (timer_r == '0) begin
                        state_s = ST_REQ;
                        stall_s = '0;
                    end else begin
                        timer_s = timer_r - TW'(1);
                    end
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_REQ: begin
                if (!avm.waitrequest) begin
                    state_s = ST_LAT;
                    lat_s   = LAT_RELOAD;
                    stall_s = '0;
                end else if (stall_r == STALL_MAX) begin
                    ovr_set_s = 1'b1;
                end else begin
                    stall_s = stall_r + STALL_W'(1);
                end
            end
            ST_LAT: begin
                if (lat_r == '0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    lat_s = lat_r - LW'(1);
                end
            end
            ST_SAMPLE: begin
                timer_s = TIMER_RELOAD;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TIMER_RELOAD;
            end
        endcase
        read_s = (state_s == ST_REQ);
    end

    // Sticky flag and press counter; clear takes priority over any set/increment.
    always_comb begin
        overrun_s = overrun_r;
        count_s   = count_r;
        if (clear) begin
            overrun_s = 1'b0;
            count_s   = 8'd0;
        end else begin
            overrun_s = overrun_r | ovr_set_s;
            count_s   = rise_s ? (count_r + 8'd1) : count_r;
        end
    end

    // State registers; reset drops avm_read immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= TIMER_RELOAD;
            lat_r     <= '0;
            stall_r   <= '0;
            read_r    <= 1'b0;
            overrun_r <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            lat_r     <= lat_s;
            stall_r   <= stall_s;
            read_r    <= read_s;
            overrun_r <= overrun_s;
            count_r   <= count_s;
        end
    end

    assign sample_s          = (state_r == ST_SAMPLE);
    assign readdata_unused_s = ^avm.readdata[DATA_W-1:1];

    verin_bp_debounce #(
        .DEB_SAMPLES (DEB_SAMPLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample_s),
        .din     (avm.readdata[0]),
        .level   (bp_level),
        .rise    (rise_s),
        .fall    (bp_fall)
    );

    assign bp_rise     = rise_s;
    assign avm.address = ADDR_C;
    assign avm.read    = read_r;
    assign press_count = count_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_verin_bp_poll_master.sv
// Scoreboard bench: slave model feeds random/patterned button bits, a window-based model predicts edges.
module tb_verin_bp_poll_master;
    import verin_bp_pkg::*;

    localparam int P   = 4;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       bp_level, bp_rise, bp_fall, overrun;
    logic [7:0] press_count;

    verin_bp_poll_master_if avm();

    verin_bp_poll_master #(
        .POLL_DIV(P), .DEB_SAMPLES(DEB), .READ_LATENCY(1), .BP_ADDR(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avm(avm), .enable(enable), .clear(clear),
        .bp_level(bp_level), .bp_rise(bp_rise), .bp_fall(bp_fall),
        .press_count(press_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- slave model / stimulus ----------------
    bit btn = 1'b1;
    bit pat_q[$];

    task automatic step();
        logic        acc;
        logic [31:0] rd;
        acc = avm.read && !avm.waitrequest && reset_n;
        @(posedge clk);
        #1;
        if (acc) begin
            rd = $urandom;
            rd[0] = (pat_q.size() > 0) ? pat_q.pop_front() : btn;
            avm.readdata = rd;
        end
    endtask

    task automatic wait_read(input string name, input int max);
        int k;
        k = 0;
        while (!avm.read && k < max) begin
            step();
            k++;
        end
        check(name, avm.read, 1'b1);
    endtask

    task automatic rand_phase(input int n, input int wr_pct);
        for (int i = 0; i < n; i++) begin
            step();
            avm.waitrequest = ($urandom_range(99) < wr_pct);
            if ($urandom_range(99) < 2) enable = ~enable;
            clear = ($urandom_range(199) == 0);
            if ($urandom_range(29) == 0) btn = ~btn;
        end
        clear  = 1'b0;
        enable = 1'b1;
        avm.waitrequest = 1'b0;
    endtask

    // ---------------- reference model / monitor ----------------
    typedef struct { int cyc; bit rise; } ev_t;
    ev_t ev_q[$];
    bit  hist[$];
    bit  mdl_lvl, cur_lvl, exp_ovr, acc_pend, prev_read, prev_wr, rise_now, all_diff, b, dummy;
    int  exp_cnt, stall_run, en_idle, idle_start;
    ev_t e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs", {avm.read, bp_level, bp_rise, bp_fall, press_count, overrun}, 32'd0);
                ev_q.delete(); hist.delete();
                mdl_lvl = 0; cur_lvl = 0; exp_ovr = 0; acc_pend = 0; prev_read = 0; prev_wr = 0;
                exp_cnt = 0; stall_run = 0; en_idle = 0; idle_start = 0;
            end else begin
                check("address", avm.address, 32'd0);
                if (prev_read && prev_wr) check("read_held_in_stall", avm.read, 1'b1);
                // Poll timing: a read starts once POLL_DIV enabled idle cycles have elapsed.
                if (avm.read && !prev_read) check("poll_interval", en_idle, P);
                else if (!avm.read && enable && cyc >= idle_start) en_idle++;
                // Debounce: level flips when the last DEB samples all differ from it.
                if (acc_pend) begin
                    b = avm.readdata[0];
                    hist.push_back(b);
                    if (hist.size() > DEB) dummy = hist.pop_front();
                    all_diff = (hist.size() == DEB);
                    foreach (hist[i]) if (hist[i] == mdl_lvl) all_diff = 0;
                    if (all_diff) begin
                        mdl_lvl = b;
                        ev_q.push_back('{cyc: cyc + 2, rise: b});
                    end
                    acc_pend = 0;
                end
                if (avm.read && !avm.waitrequest) begin
                    acc_pend = 1; idle_start = cyc + 3; en_idle = 0;
                end
                rise_now = 0;
                if (bp_rise || bp_fall || (ev_q.size() > 0 && ev_q[0].cyc <= cyc)) begin
                    if (ev_q.size() == 0) begin
                        check("unexpected_edge", {bp_rise, bp_fall}, 32'd0);
                    end else begin
                        e = ev_q.pop_front();
                        check("edge_cycle", cyc, e.cyc);
                        check("edge_kind", {bp_rise, bp_fall}, e.rise ? 32'd2 : 32'd1);
                        cur_lvl = e.rise; rise_now = e.rise;
                    end
                end
                check("bp_level", bp_level, cur_lvl);
                check("press_count", press_count, exp_cnt);
                check("overrun", overrun, exp_ovr);
                if (avm.read && avm.waitrequest) stall_run++;
                if (avm.read && !avm.waitrequest) stall_run = 0;
                exp_ovr = clear ? 1'b0 : ((avm.read && avm.waitrequest && stall_run >= 256) ? 1'b1 : exp_ovr);
                exp_cnt = clear ? 0 : (rise_now ? (exp_cnt + 1) % 256 : exp_cnt);
                prev_read = avm.read;
                prev_wr   = avm.waitrequest;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        n_fail++;
        $display("FAIL watchdog: bench exceeded its time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    int  t0, k;
    bit  clear_done;

    initial begin : driver
        avm.waitrequest = 1'b0;
        avm.readdata    = 32'hFFFF_FFFF;
        enable          = 1'b1;
        repeat (5) step();
        reset_n = 1'b1;

        // Poll period with no stall
        wait_read("first_read", 50);
        t0 = cyc;
        step();
        wait_read("second_read", 50);
        check("poll_period", cyc - t0, P + 3);
        repeat (40) step();

        // Debounce patterns including an interrupted run
        for (int i = 0; i < 5; i++) pat_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) pat_q.push_back(1'b0);
        pat_q.push_back(1'b1); pat_q.push_back(1'b1); pat_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
        k = 0;
        while (pat_q.size() > 0 && k < 3000) begin step(); k++; end
        check("pattern_drain", pat_q.size(), 32'd0);

        // Many presses: counter wraps; one clear lands on a rise
        for (int i = 0; i < 270; i++) begin
            repeat (DEB) pat_q.push_back(1'b0);
            repeat (DEB) pat_q.push_back(1'b1);
        end
        clear_done = 1'b0;
        k = 0;
        while (pat_q.size() > 0 && k < 20000) begin
            step();
            k++;
            if (!clear_done && bp_rise && pat_q.size() < 2100) begin
                clear = 1'b1; clear_done = 1'b1;
            end else begin
                clear = 1'b0;
            end
        end
        clear = 1'b0;
        check("wrap_drain", pat_q.size(), 32'd0);
        repeat (20) step();

        // Long stall during REQ
        wait_read("stall_read", 100);
        avm.waitrequest = 1'b1;
        btn = ~btn;
        repeat (300) step();
        avm.waitrequest = 1'b0;
        repeat (20) step();
        check("overrun_sticky", overrun, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("overrun_cleared", overrun, 1'b0);

        // enable dropped during LAT: transaction completes, then parks
        wait_read("lat_read", 100);
        step();
        enable = 1'b0;
        repeat (60) step();
        check("parked_no_read", avm.read, 1'b0);
        enable = 1'b1;
        repeat (30) step();

        // Random traffic
        rand_phase(3000, 15);

        // Reset in the middle of a read
        wait_read("reset_read", 100);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_read_drop", avm.read, 1'b0);
        repeat (3) step();
        reset_n = 1'b1;

        rand_phase(1500, 10);
        enable = 1'b0;
        repeat (30) step();
        check("events_drained", ev_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
